// File: rtl/kugelblitz_rewrite_ctrl.sv
// rtl/kugelblitz_rewrite_ctrl.sv - frame-aligned first-beat byte-rewrite controller
// Optional feature macro: KUGELBLITZ_REWRITE_STATS_EN (adds stat_rewrite_frames counter)
module kugelblitz_rewrite_ctrl #(
   parameter int DATA_WIDTH  = 512,
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int USER_WIDTH  = 1,
   parameter int ENTRY_COUNT = 4,
   parameter int IDX_WIDTH   = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_wr_en,
   input  logic [IDX_WIDTH-1:0]  cfg_wr_index,
   input  logic [5:0]            cfg_wr_offset,
   input  logic [7:0]            cfg_wr_data,
   input  logic                  cfg_wr_valid,
   input  logic                  cfg_commit,
   output logic                  cfg_commit_pending,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
`ifdef KUGELBLITZ_REWRITE_STATS_EN
   output logic [31:0]           stat_rewrite_frames,
`endif
   output logic [USER_WIDTH-1:0] m_axis_tuser
);

   generate
      if (DATA_WIDTH != 512) begin : g_bad_data_width
         $error("kugelblitz_rewrite_ctrl: DATA_WIDTH must be 512");
      end
      if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep_width
         $error("kugelblitz_rewrite_ctrl: KEEP_WIDTH*8 must equal DATA_WIDTH");
      end
      if (ENTRY_COUNT < 1 || ENTRY_COUNT > 16) begin : g_bad_entry_count
         $error("kugelblitz_rewrite_ctrl: ENTRY_COUNT must be 1..16");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic                        pending_q, pending_d;
   logic                        commit_fire;
   logic                        s_accept;

   logic [ENTRY_COUNT-1:0]      sh_valid_q, sh_valid_d;
   logic [ENTRY_COUNT-1:0][5:0] sh_offset_q, sh_offset_d;
   logic [ENTRY_COUNT-1:0][7:0] sh_data_q, sh_data_d;

   logic [ENTRY_COUNT-1:0]      act_valid_q;
   logic [ENTRY_COUNT-1:0][5:0] act_offset_q;
   logic [ENTRY_COUNT-1:0][7:0] act_data_q;

   logic [DATA_WIDTH-1:0]       rw_data;
   logic                        rw_hit;

   assign s_axis_tready      = !m_axis_tvalid || m_axis_tready;
   assign s_accept           = s_axis_tvalid && s_axis_tready;
   assign cfg_commit_pending = pending_q;

   // Shadow table with this cycle's write folded in, so a coincident commit sees it
   always_comb begin
      sh_valid_d  = sh_valid_q;
      sh_offset_d = sh_offset_q;
      sh_data_d   = sh_data_q;
      if (cfg_wr_en && (int'(cfg_wr_index) < ENTRY_COUNT)) begin
         sh_valid_d[cfg_wr_index]  = cfg_wr_valid;
         sh_offset_d[cfg_wr_index] = cfg_wr_offset;
         sh_data_d[cfg_wr_index]   = cfg_wr_data;
      end
   end

   // Frame-position next state and commit-point detection
   always_comb begin
      state_d     = state_q;
      commit_fire = 1'b0;
      pending_d   = pending_q;
      if (s_accept) begin
         state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
      end
      if (pending_q && (((state_q == ST_IDLE) && !s_accept) || (s_accept && s_axis_tlast))) begin
         commit_fire = 1'b1;
      end
      if (cfg_commit) begin
         pending_d = 1'b1;
      end else if (commit_fire) begin
         pending_d = 1'b0;
      end
   end

   // Zero masked lanes, then overlay active rules on the first beat (ascending index so the highest wins)
   always_comb begin
      rw_data = '0;
      rw_hit  = 1'b0;
      for (int b = 0; b < KEEP_WIDTH; b++) begin
         if (s_axis_tkeep[b]) begin
            rw_data[b*8 +: 8] = s_axis_tdata[b*8 +: 8];
         end
      end
      if (state_q == ST_IDLE) begin
         for (int e = 0; e < ENTRY_COUNT; e++) begin
            if (act_valid_q[e] && s_axis_tkeep[act_offset_q[e]]) begin
               rw_data[int'(act_offset_q[e])*8 +: 8] = act_data_q[e];
               rw_hit = 1'b1;
            end
         end
      end
   end

   // FSM, commit flag and rule tables
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pending_q    <= 1'b0;
         sh_valid_q   <= '0;
         sh_offset_q  <= '0;
         sh_data_q    <= '0;
         act_valid_q  <= '0;
         act_offset_q <= '0;
         act_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         sh_valid_q  <= sh_valid_d;
         sh_offset_q <= sh_offset_d;
         sh_data_q   <= sh_data_d;
         if (commit_fire) begin
            act_valid_q  <= sh_valid_d;
            act_offset_q <= sh_offset_d;
            act_data_q   <= sh_data_d;
         end
      end
   end

   // Single output register stage; loads only when the downstream slot is free
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else if (s_axis_tready) begin
         m_axis_tvalid <= s_axis_tvalid;
         if (s_axis_tvalid) begin
            m_axis_tdata <= rw_data;
            m_axis_tkeep <= s_axis_tkeep;
            m_axis_tlast <= s_axis_tlast;
            m_axis_tuser <= s_axis_tuser;
         end
      end
   end

`ifdef KUGELBLITZ_REWRITE_STATS_EN
   // Count first beats that had at least one byte replaced; wraps naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rewrite_frames <= '0;
      end else if (s_accept && rw_hit) begin
         stat_rewrite_frames <= stat_rewrite_frames + 32'd1;
      end
   end
`else
   logic unused_rw_hit;
   assign unused_rw_hit = rw_hit;
`endif

endmodule
